// File: rtl/bytecode_prefetch_queue_if.sv
// rtl/bytecode_prefetch_queue_if.sv - decoder and instruction-memory signals of the bytecode prefetch queue
interface bytecode_prefetch_queue_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int WORD_BYTES    = 4,
    parameter int QUEUE_DEPTH   = 8,
    parameter int PEEK          = 4
);
    localparam int CONSUME_W = $clog2(PEEK + 1);
    localparam int COUNT_W   = $clog2(QUEUE_DEPTH + 1);

    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirect_addr;
    logic [CONSUME_W-1:0]     consume;
    logic                     mem_req;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_ack;
    logic [8*WORD_BYTES-1:0]  mem_rdata;
    logic [8*PEEK-1:0]        out_bytes;
    logic [COUNT_W-1:0]       out_count;
    logic [ADDRESS_WIDTH-1:0] pc;

    // master is the prefetch queue; slave is the decoder plus instruction memory
    modport master (
        input  redirect, redirect_addr, consume, mem_ack, mem_rdata,
        output mem_req, mem_addr, out_bytes, out_count, pc
    );

    modport slave (
        output redirect, redirect_addr, consume, mem_ack, mem_rdata,
        input  mem_req, mem_addr, out_bytes, out_count, pc
    );
endinterface

// File: rtl/bytecode_prefetch_queue.sv
// rtl/bytecode_prefetch_queue.sv - word-fetching byte FIFO feeding a variable-length bytecode decoder
module bytecode_prefetch_queue #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int WORD_BYTES    = 4,
    parameter int QUEUE_DEPTH   = 8,
    parameter int PEEK          = 4
) (
    input  logic                     clk,
    input  logic                     pc_reset,
    input  logic [ADDRESS_WIDTH-1:0] pc_reset_value,
    bytecode_prefetch_queue_if.master bus
);
    localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int SKIP_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int COUNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [ADDRESS_WIDTH-1:0] LOW_MASK = ADDRESS_WIDTH'(WORD_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t                   state;
    logic [7:0]               fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [COUNT_W-1:0]       count;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] fetch_addr;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [SKIP_W-1:0]        skip;
    logic                     mem_req_q;

    logic [COUNT_W-1:0]       consumed;
    logic [COUNT_W-1:0]       appended;
    logic                     take_data;
    logic                     space_ok;
    logic [8*PEEK-1:0]        head;

    always_comb begin
        consumed  = (COUNT_W'(bus.consume) > count) ? count : COUNT_W'(bus.consume);
        appended  = COUNT_W'(WORD_BYTES) - COUNT_W'(skip);
        take_data = (state == S_REQ) && bus.mem_ack && !bus.redirect;
        space_ok  = (QUEUE_DEPTH - int'(count)) >= WORD_BYTES;
    end

    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pc_q       <= pc_reset_value;
            fetch_addr <= pc_reset_value & ~LOW_MASK;
            mem_addr_q <= pc_reset_value & ~LOW_MASK;
            skip       <= SKIP_W'(pc_reset_value & LOW_MASK);
            mem_req_q  <= 1'b0;
        end else if (bus.redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pc_q       <= bus.redirect_addr;
            fetch_addr <= bus.redirect_addr & ~LOW_MASK;
            skip       <= SKIP_W'(bus.redirect_addr & LOW_MASK);
            // An unacked request must still complete on the bus; its data is dropped in DISCARD.
            case (state)
                S_REQ, S_DISCARD: begin
                    if (bus.mem_ack) begin
                        state     <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end else begin
                        state <= S_DISCARD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(consumed);
            pc_q   <= pc_q + ADDRESS_WIDTH'(consumed);
            count  <= count - consumed + (take_data ? appended : '0);
            case (state)
                S_IDLE: begin
                    if (space_ok) begin
                        state      <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_addr;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        wr_ptr     <= wr_ptr + PTR_W'(appended);
                        skip       <= '0;
                        fetch_addr <= fetch_addr + ADDRESS_WIDTH'(WORD_BYTES);
                        state      <= S_IDLE;
                        mem_req_q  <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (bus.mem_ack) begin
                        state     <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bytes below skip belong to the word but precede the target pc, so they never enter the FIFO.
    always_ff @(posedge clk) begin
        if (take_data) begin
            for (int j = 0; j < WORD_BYTES; j++) begin
                if (j >= int'(skip)) begin
                    fifo_mem[wr_ptr + PTR_W'(j - int'(skip))] <= bus.mem_rdata[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < PEEK; i++) begin
            if (i < int'(count)) begin
                head[8*i +: 8] = fifo_mem[rd_ptr + PTR_W'(i)];
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_bytes = head;
    assign bus.out_count = count;
    assign bus.pc        = pc_q;
endmodule

// File: tb/tb_bytecode_prefetch_queue.sv
// tb/tb_bytecode_prefetch_queue.sv - randomized and directed bench for bytecode_prefetch_queue against a byte-queue model
module tb_bytecode_prefetch_queue;
    localparam int AW = 8;
    localparam int WB = 4;
    localparam int QD = 8;
    localparam int PK = 4;

    logic          clk;
    logic          pc_reset;
    logic [AW-1:0] pc_reset_value;

    bytecode_prefetch_queue_if #(.ADDRESS_WIDTH(AW), .WORD_BYTES(WB), .QUEUE_DEPTH(QD), .PEEK(PK)) bus ();

    bytecode_prefetch_queue #(.ADDRESS_WIDTH(AW), .WORD_BYTES(WB), .QUEUE_DEPTH(QD), .PEEK(PK)) dut (
        .clk            (clk),
        .pc_reset       (pc_reset),
        .pc_reset_value (pc_reset_value),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 0;

    // Behavioural model: decoder-visible byte queue plus the one outstanding memory read.
    logic [7:0]    m_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_fetch;
    logic [AW-1:0] m_addr;
    int            m_skip;
    bit            m_req;
    bit            m_stale;

    // Memory responder state
    logic [AW-1:0] req_log[$];
    bit            req_seen;
    int            wait_cnt;
    int            fixed_delay;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = pc_reset_value;
        m_fetch = pc_reset_value & ~AW'(WB - 1);
        m_skip  = int'(pc_reset_value) % WB;
        m_req   = 0;
        m_stale = 0;
    endtask

    task automatic model_step();
        int room;
        int n;
        room = QD - m_q.size();
        if (bus.redirect) begin
            m_q.delete();
            m_pc    = bus.redirect_addr;
            m_fetch = bus.redirect_addr & ~AW'(WB - 1);
            m_skip  = int'(bus.redirect_addr) % WB;
            if (m_req && bus.mem_ack) begin
                m_req   = 0;
                m_stale = 0;
            end else if (m_req) begin
                m_stale = 1;
            end
        end else begin
            n = int'(bus.consume);
            if (n > m_q.size()) n = m_q.size();
            repeat (n) void'(m_q.pop_front());
            m_pc = AW'(int'(m_pc) + n);
            if (m_req) begin
                if (bus.mem_ack) begin
                    if (!m_stale) begin
                        for (int j = m_skip; j < WB; j++) m_q.push_back(mem_byte(AW'(int'(m_fetch) + j)));
                        m_fetch = AW'(int'(m_fetch) + WB);
                        m_skip  = 0;
                    end
                    m_req   = 0;
                    m_stale = 0;
                end
            end else if (room >= WB) begin
                m_req  = 1;
                m_addr = m_fetch;
            end
        end
    endtask

    always @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req", 32'(bus.mem_req), 32'(m_req));
            if (m_req) check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            check("out_count", 32'(bus.out_count), 32'(m_q.size()));
            check("pc", 32'(bus.pc), 32'(m_pc));
            for (int i = 0; i < PK; i++) begin
                if (i < m_q.size()) check("out_lane", 32'(bus.out_bytes[8*i +: 8]), 32'(m_q[i]));
            end
        end
    end

    task automatic respond();
        if (!pc_reset) begin
            bus.mem_ack = 1'b0;
            req_seen    = 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            req_seen    = 0;
        end else if (bus.mem_req) begin
            if (!req_seen) begin
                req_seen = 1;
                wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
            if (wait_cnt == 0) begin
                bus.mem_ack = 1'b1;
                for (int j = 0; j < WB; j++) bus.mem_rdata[8*j +: 8] = mem_byte(AW'(int'(bus.mem_addr) + j));
                req_log.push_back(bus.mem_addr);
            end else begin
                wait_cnt--;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        respond();
    endtask

    task automatic do_reset(input logic [AW-1:0] v);
        chk_en = 0;
        @(negedge clk);
        pc_reset_value    = v;
        pc_reset          = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.consume       = '0;
        bus.mem_ack       = 1'b0;
        req_seen          = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_out_bytes", 32'(bus.out_bytes), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'(v));
        req_log.delete();
        pc_reset = 1'b1;
        chk_en   = 1;
    endtask

    initial begin
        int exp_b;
        int k;
        pc_reset          = 1'b0;
        pc_reset_value    = '0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.consume       = '0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = '0;
        fixed_delay       = 0;

        // Fill from 0x00 with no consumption
        do_reset(8'h00);
        repeat (14) cycle();
        check("fill_nreq", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            check("fill_req0", 32'(req_log[0]), 32'h00);
            check("fill_req1", 32'(req_log[1]), 32'h04);
        end
        check("fill_count", 32'(bus.out_count), 32'd8);
        check("fill_bytes", 32'(bus.out_bytes), 32'h03020100);
        check("fill_pc", 32'(bus.pc), 32'h00);

        // Unaligned start, then over-consume
        do_reset(8'h06);
        for (k = 0; k < 20 && req_log.size() < 1; k++) cycle();
        check("unal_seen", 32'(req_log.size() >= 1), 32'd1);
        if (req_log.size() >= 1) check("unal_req0", 32'(req_log[0]), 32'h04);
        cycle();
        check("unal_count", 32'(bus.out_count), 32'd2);
        check("unal_bytes", 32'(bus.out_bytes[15:0]), 32'h0706);
        bus.consume = 3'd4;
        cycle();
        bus.consume = '0;
        check("clamp_count", 32'(bus.out_count), 32'd0);
        check("clamp_pc", 32'(bus.pc), 32'h08);

        // Simultaneous ack and consume at out_count=4
        do_reset(8'h00);
        for (k = 0; k < 20 && req_log.size() < 2; k++) cycle();
        check("simul_pre_count", 32'(bus.out_count), 32'd4);
        bus.consume = 3'd2;
        cycle();
        bus.consume = '0;
        check("simul_count", 32'(bus.out_count), 32'd6);
        check("simul_pc", 32'(bus.pc), 32'h02);
        check("simul_bytes", 32'(bus.out_bytes), 32'h05040302);

        // Streaming 3 bytes per cycle with random memory latency
        fixed_delay = -1;
        do_reset(8'h00);
        exp_b = 0;
        for (k = 0; k < 600 && exp_b < 64; k++) begin
            cycle();
            if (m_q.size() >= 3) begin
                check("stream_pc", 32'(bus.pc), 32'(AW'(exp_b)));
                for (int i = 0; i < 3; i++) check("stream_byte", 32'(bus.out_bytes[8*i +: 8]), 32'(AW'(exp_b + i)));
                bus.consume = 3'd3;
                exp_b += 3;
            end else begin
                bus.consume = '0;
            end
        end
        bus.consume = '0;
        check("stream_done", 32'(exp_b >= 64), 32'd1);

        // Redirect while the read of 0x08 is outstanding
        fixed_delay = 0;
        do_reset(8'h00);
        repeat (12) cycle();
        bus.consume = 3'd4;
        cycle();
        bus.consume = '0;
        fixed_delay = 3;
        for (k = 0; k < 10 && !bus.mem_req; k++) cycle();
        check("redir_req_up", 32'(bus.mem_req), 32'd1);
        check("redir_req_addr", 32'(bus.mem_addr), 32'h08);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'h21;
        cycle();
        bus.redirect = 1'b0;
        check("redir_hold", 32'(bus.mem_req), 32'd1);
        for (k = 0; k < 40 && req_log.size() < 4; k++) cycle();
        repeat (3) cycle();
        check("redir_nreq", 32'(req_log.size() >= 4), 32'd1);
        if (req_log.size() >= 4) begin
            check("redir_stale", 32'(req_log[2]), 32'h08);
            check("redir_next", 32'(req_log[3]), 32'h20);
        end
        check("redir_count", 32'(bus.out_count), 32'd3);
        check("redir_byte0", 32'(bus.out_bytes[7:0]), 32'h21);
        check("redir_pc", 32'(bus.pc), 32'h21);

        // Asynchronous reset in the middle of an outstanding read
        do_reset(8'h13);
        for (k = 0; k < 10 && !bus.mem_req; k++) cycle();
        check("mid_req_up", 32'(bus.mem_req), 32'd1);
        #2;
        pc_reset_value = 8'h2B;
        pc_reset       = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_count", 32'(bus.out_count), 32'd0);
        bus.mem_ack = 1'b0;
        req_seen    = 0;
        req_log.delete();
        @(negedge clk);
        pc_reset    = 1'b1;
        fixed_delay = 0;
        for (k = 0; k < 10 && req_log.size() < 1; k++) cycle();
        check("mid_after_seen", 32'(req_log.size() >= 1), 32'd1);
        if (req_log.size() >= 1) check("mid_after_addr", 32'(req_log[0]), 32'h28);
        check("mid_after_pc", 32'(bus.pc), 32'h2B);

        // Randomized traffic with redirects, checked every cycle by the model
        fixed_delay = -1;
        do_reset(AW'($urandom));
        for (k = 0; k < 3000; k++) begin
            cycle();
            bus.consume       = 3'($urandom_range(0, PK));
            bus.redirect      = ($urandom_range(0, 24) == 0);
            bus.redirect_addr = AW'($urandom);
        end
        bus.redirect = 1'b0;
        bus.consume  = '0;
        repeat (4) cycle();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
